// File: rtl/dmux8way16_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmux8way16_reg_pkg
// Purpose  : Shared definitions for the registered 8-way demultiplexer:
//            channel count, select width and the out_data slice-offset helper.
// Revision : 1.0 - initial release
// ============================================================================
package dmux8way16_reg_pkg;

    localparam int DMUX_WAYS  = 8;
    localparam int DMUX_SEL_W = 3;

    // Bit offset of channel k inside the packed out_data bus.
    function automatic int dmux_slice_lsb(input int k, input int width);
        return k * width;
    endfunction

endpackage : dmux8way16_reg_pkg
`default_nettype wire

// File: rtl/dmux_slot.sv
`default_nettype none
// ============================================================================
// Module   : dmux_slot
// Purpose  : One output channel of the demultiplexer: a one-entry register
//            with a full flag and valid/ready handshake towards its consumer.
// Ports    : clk, reset (async, active-high)
//            i_load       - load i_data this cycle (already qualified by accept)
//            i_data       - word to load
//            i_out_ready  - consumer takes the held word this cycle
//            o_full       - channel holds a word (drives out_valid[k])
//            o_data       - held word (drives slice k of out_data)
//            o_can_accept - channel is empty or drains this cycle
// Revision : 1.0 - initial release
// ============================================================================
module dmux_slot #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_out_ready,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data,
    output logic             o_can_accept
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_drain;

    assign w_drain      = r_full & i_out_ready;
    // Accepting while draining keeps one-word-per-cycle throughput.
    assign o_can_accept = ~r_full | w_drain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            // Load wins over drain: the flag stays set and the new word replaces the old.
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (w_drain) begin
            // Data is left as-is; it is don't-care once the flag is clear.
            r_full <= 1'b0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;

endmodule : dmux_slot
`default_nettype wire

// File: rtl/dmux8way16_reg.sv
`default_nettype none
// ============================================================================
// Module   : dmux8way16_reg
// Purpose  : Registered 8-way WIDTH-bit demultiplexer with valid/ready flow
//            control. Each word goes to the channel chosen by in_sel and is
//            held there until that channel's consumer takes it.
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready/in_data/in_sel - producer stream
//            in_bcast  - broadcast to all channels (only with DMUX8WAY16_BCAST_EN)
//            out_valid/out_ready/out_data     - eight consumer channels,
//                        channel k on out_data[WIDTH*k +: WIDTH]
// Config   : `define DMUX8WAY16_BCAST_EN to add the in_bcast port.
// Revision : 1.0 - initial release
// ============================================================================
module dmux8way16_reg
    import dmux8way16_reg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [DMUX_SEL_W-1:0]      in_sel,
`ifdef DMUX8WAY16_BCAST_EN
    input  logic                       in_bcast,
`endif
    output logic [DMUX_WAYS-1:0]       out_valid,
    input  logic [DMUX_WAYS-1:0]       out_ready,
    output logic [DMUX_WAYS*WIDTH-1:0] out_data
);

    logic [DMUX_WAYS-1:0] w_can_accept;
    logic [DMUX_WAYS-1:0] w_sel_dec;
    logic [DMUX_WAYS-1:0] w_load;
    logic                 w_accept;

    // One-hot decode of the destination channel.
    always_comb begin
        w_sel_dec         = '0;
        w_sel_dec[in_sel] = 1'b1;
    end

    // in_ready never looks at in_valid, so the producer may wait on it freely.
`ifdef DMUX8WAY16_BCAST_EN
    assign in_ready = in_bcast ? (&w_can_accept) : w_can_accept[in_sel];
    assign w_accept = in_valid & in_ready;
    assign w_load   = in_bcast ? {DMUX_WAYS{w_accept}}
                               : (w_sel_dec & {DMUX_WAYS{w_accept}});
`else
    assign in_ready = w_can_accept[in_sel];
    assign w_accept = in_valid & in_ready;
    assign w_load   = w_sel_dec & {DMUX_WAYS{w_accept}};
`endif

    for (genvar k = 0; k < DMUX_WAYS; k++) begin : g_slot
        dmux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk          (clk),
            .reset        (reset),
            .i_load       (w_load[k]),
            .i_data       (in_data),
            .i_out_ready  (out_ready[k]),
            .o_full       (out_valid[k]),
            .o_data       (out_data[dmux_slice_lsb(k, WIDTH) +: WIDTH]),
            .o_can_accept (w_can_accept[k])
        );
    end : g_slot

endmodule : dmux8way16_reg
`default_nettype wire
